// File: rtl/load_store_unit.sv
// Load/store sequencer between EX/MEM and a word-addressed data memory bank.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_error,
    output logic        memReadFlag,
    output logic        memWriteFlag,
    output logic [31:0] MemAddress,
    output logic [31:0] WriteDataInput,
    input  logic [31:0] ReadDataOutput
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q;
    logic        write_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;

    logic [1:0]  lane_d;
    logic        err_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;

    assign req_ready = (state_q == IDLE);

    // Request classification: reserved size always errors; misalignment traps or is masked off.
    always_comb begin
        lane_d = req_addr[1:0];
        err_d  = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_size == 2'b01 && req_addr[0])
            err_d = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            err_d = 1'b1;
`else
        if (req_size == 2'b01)
            lane_d[0] = 1'b0;
        if (req_size == 2'b10)
            lane_d = 2'b00;
`endif
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        logic [31:0] shifted;
        logic [31:0] mask;
        logic [31:0] data;
        shifted = ReadDataOutput >> {lane_q, 3'b000};
        mask    = 32'h0;
        data    = 32'h0;
        load_d  = ReadDataOutput;
        merge_d = wdata_q;
        case (size_q)
            2'b00: begin
                load_d = unsigned_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                mask   = 32'h0000_00FF << {lane_q, 3'b000};
                data   = {24'h0, wdata_q[7:0]} << {lane_q, 3'b000};
            end
            2'b01: begin
                load_d = unsigned_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                mask   = 32'h0000_FFFF << {lane_q, 3'b000};
                data   = {16'h0, wdata_q[15:0]} << {lane_q, 3'b000};
            end
            default: ;
        endcase
        if (size_q != 2'b10)
            merge_d = (ReadDataOutput & ~mask) | (data & mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            write_q        <= 1'b0;
            unsigned_q     <= 1'b0;
            size_q         <= 2'b00;
            lane_q         <= 2'b00;
            wdata_q        <= 32'h0;
            rd_q           <= 5'h0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h0;
            resp_rd        <= 5'h0;
            resp_error     <= 1'b0;
            memReadFlag    <= 1'b0;
            memWriteFlag   <= 1'b0;
            MemAddress     <= 32'h0;
            WriteDataInput <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        lane_q     <= lane_d;
                        wdata_q    <= req_wdata;
                        rd_q       <= req_rd;
                        if (err_d) begin
                            state_q    <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                            resp_rd    <= 5'h0;
                        end else if (req_write && req_size == 2'b10) begin
                            state_q        <= WRITE;
                            memWriteFlag   <= 1'b1;
                            MemAddress     <= {2'b00, req_addr[31:2]};
                            WriteDataInput <= req_wdata;
                        end else begin
                            state_q     <= READ;
                            memReadFlag <= 1'b1;
                            MemAddress  <= {2'b00, req_addr[31:2]};
                        end
                    end
                end
                READ: begin
                    memReadFlag <= 1'b0;
                    if (write_q) begin
                        state_q        <= WRITE;
                        memWriteFlag   <= 1'b1;
                        WriteDataInput <= merge_d;
                    end else begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_d;
                        resp_rd    <= rd_q;
                        resp_error <= 1'b0;
                    end
                end
                WRITE: begin
                    memWriteFlag <= 1'b0;
                    state_q      <= RESP;
                    resp_valid   <= 1'b1;
                    resp_rdata   <= 32'h0;
                    resp_rd      <= 5'h0;
                    resp_error   <= 1'b0;
                end
                RESP: begin
                    state_q    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0;
                    resp_rd    <= 5'h0;
                    resp_error <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array reference model, directed and random traffic.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        memReadFlag, memWriteFlag;
    logic [31:0] MemAddress, WriteDataInput, ReadDataOutput;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_error(resp_error), .memReadFlag(memReadFlag), .memWriteFlag(memWriteFlag),
        .MemAddress(MemAddress), .WriteDataInput(WriteDataInput),
        .ReadDataOutput(ReadDataOutput)
    );

    // 64-word memory; higher address bits alias, as a real shallow bank would.
    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'h0;
    logic [31:0] pl_val = 32'h0;
    assign ReadDataOutput = mem[MemAddress[5:0]];
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (memWriteFlag)
            mem[MemAddress[5:0]] <= WriteDataInput;
    end

    logic [7:0] ref_b [0:255];
    int  checks = 0;
    int  errors = 0;
    bit  trap;

    task automatic set_word(input int idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = 6'(idx); pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_b[idx * 4 + i] = 8'(val >> (8 * i));
        @(negedge clk);
    endtask

    // Drives one request and compares every observable against the byte-level model.
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        logic        exp_err;
        int          n, b0, w0, exp_lat, exp_reads, exp_writes;
        logic [31:0] exp_rdata, exp_wword, exp_idx;
        logic [4:0]  exp_rd;
        int          lat, reads, writes;
        bit          both, bad_addr;
        logic [31:0] obs_wword, obs_rdata;
        logic [4:0]  obs_rd;
        logic        obs_err, obs_ready;

        exp_err = (sz == 2'b11) ||
                  (trap && ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)));
        n = (sz == 2'b11) ? 0 : (1 << sz);
        b0 = int'(addr[7:0]);
        if (n > 0) b0 = b0 - (b0 % n);
        w0 = b0 - (b0 % 4);
        exp_idx = {2'b00, addr[31:2]};
        exp_rdata = 32'h0; exp_rd = 5'h0; exp_wword = 32'h0;
        exp_reads = 0; exp_writes = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!wr) begin
            exp_lat = 2; exp_reads = 1; exp_rd = rd;
            for (int i = 0; i < n; i++) exp_rdata = exp_rdata | (32'(ref_b[b0 + i]) << (8 * i));
            if (!uns && n < 4 && exp_rdata[8 * n - 1]) exp_rdata = exp_rdata | (32'hFFFF_FFFF << (8 * n));
        end else begin
            exp_lat = (n == 4) ? 2 : 3; exp_writes = 1; exp_reads = (n == 4) ? 0 : 1;
            for (int i = 0; i < n; i++) ref_b[b0 + i] = 8'(wd >> (8 * i));
            for (int i = 0; i < 4; i++) exp_wword = exp_wword | (32'(ref_b[w0 + i]) << (8 * i));
        end

        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_idle: got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);

        lat = -1; reads = 0; writes = 0; both = 0; bad_addr = 0; obs_wword = 32'h0;
        obs_rdata = 32'h0; obs_rd = 5'h0; obs_err = 1'b0; obs_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (memReadFlag && memWriteFlag) both = 1;
            if (memReadFlag) begin reads++; if (MemAddress !== exp_idx) bad_addr = 1; end
            if (memWriteFlag) begin writes++; obs_wword = WriteDataInput; if (MemAddress !== exp_idx) bad_addr = 1; end
            if (resp_valid) begin
                lat = k; obs_rdata = resp_rdata; obs_rd = resp_rd; obs_err = resp_error; obs_ready = req_ready;
                break;
            end
        end
        $display("txn wr=%0b sz=%0d uns=%0b addr=%h wd=%h rd=%0d -> lat=%0d err=%0b rdata=%h rd=%0d",
                 wr, sz, uns, addr, wd, rd, lat, obs_err, obs_rdata, obs_rd);

        checks++; if (lat != exp_lat) begin errors++; $display("FAIL latency: got %0d want %0d", lat, exp_lat); end
        checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL resp_error: got %b want %b", obs_err, exp_err); end
        checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL resp_rdata: got %h want %h", obs_rdata, exp_rdata); end
        checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL resp_rd: got %0d want %0d", obs_rd, exp_rd); end
        checks++; if (reads != exp_reads) begin errors++; $display("FAIL read_cycles: got %0d want %0d", reads, exp_reads); end
        checks++; if (writes != exp_writes) begin errors++; $display("FAIL write_cycles: got %0d want %0d", writes, exp_writes); end
        checks++; if (both || bad_addr) begin errors++; $display("FAIL mem_bus: both=%0b bad_addr=%0b want 0 0 (idx %h)", both, bad_addr, exp_idx); end
        if (exp_writes == 1) begin
            checks++; if (obs_wword !== exp_wword) begin errors++; $display("FAIL write_word: got %h want %h", obs_wword, exp_wword); end
        end
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL ready_in_resp: got %b want 0", obs_ready); end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_rd !== 5'h0 || resp_error !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL post_resp: got v=%b d=%h rd=%0d e=%b rdy=%b want 0 0 0 0 1",
                               resp_valid, resp_rdata, resp_rd, resp_error, req_ready);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'h0 || resp_rd !== 5'h0) begin
            errors++; $display("FAIL reset_resp: rdy=%b v=%b e=%b d=%h rd=%0d want 1 0 0 0 0",
                               req_ready, resp_valid, resp_error, resp_rdata, resp_rd);
        end
        checks++;
        if (memReadFlag !== 1'b0 || memWriteFlag !== 1'b0 || MemAddress !== 32'h0 || WriteDataInput !== 32'h0) begin
            errors++; $display("FAIL reset_mem: r=%b w=%b a=%h wd=%h want 0 0 0 0",
                               memReadFlag, memWriteFlag, MemAddress, WriteDataInput);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
    endtask

    task automatic test_directed;
        run_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3);
        run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd7);
        set_word(4, 32'h11223344);
        run_txn(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFA5, 5'd1);
        checks++;
        if (mem[4] !== 32'h1122A544) begin errors++; $display("FAIL byte_merge: got %h want 1122a544", mem[4]); end
        run_txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 5'd9);
        run_txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 5'd10);
        run_txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_8001, 5'd2);
        run_txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 5'd11);
        run_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd12);
        checks++;
        if (mem[4] !== 32'h8001A544) begin errors++; $display("FAIL half_merge: got %h want 8001a544", mem[4]); end
        run_txn(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 5'd13);
        run_txn(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 5'd14);
        run_txn(1'b1, 2'b11, 1'b0, 32'h24, 32'h5555_5555, 5'd15);
        run_txn(1'b1, 2'b01, 1'b0, 32'h27, 32'h0000_BEEF, 5'd4);
        run_txn(1'b0, 2'b01, 1'b1, 32'hFFFF_FF27, 32'h0, 5'd5);
    endtask

    task automatic test_random;
        for (int t = 0; t < 200; t++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_txn(1'($urandom), sz, 1'($urandom), $urandom, $urandom, 5'($urandom));
        end
    endtask

    task automatic test_reset_mid_write;
        int w;
        set_word(5, 32'hCAFEF00D);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h15;
        req_wdata = 32'h0000_0077; req_rd = 5'd6; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!memWriteFlag && w < 6);
        checks++;
        if (memWriteFlag !== 1'b1) begin errors++; $display("FAIL midwrite_reach: got %b want 1", memWriteFlag); end
        rst_n = 1'b0; #1;
        checks++;
        if (memWriteFlag !== 1'b0 || memReadFlag !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL midwrite_reset: w=%b r=%b v=%b rdy=%b want 0 0 0 1",
                               memWriteFlag, memReadFlag, resp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL after_reset: v=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
        checks++;
        if (mem[5] !== 32'hCAFEF00D && mem[5] !== 32'hCAFE770D) begin
            errors++; $display("FAIL midwrite_word: got %h want cafef00d or cafe770d", mem[5]);
        end
        for (int i = 0; i < 4; i++) ref_b[20 + i] = 8'(mem[5] >> (8 * i));
        run_txn(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 5'd8);
    endtask

    initial begin
`ifdef LSU_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        test_reset;
        test_directed;
        test_random;
        test_reset_mid_write;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
